// File: rtl/pc_pkg.sv
// Shared constants for the fetch PC generator: redirect addressing modes,
// FSM state encoding and the target alignment rule.
package pc_pkg;

    localparam logic [1:0] PC_REL  = 2'd0;
    localparam logic [1:0] REG_REL = 2'd1;
    localparam logic [1:0] ABS     = 2'd2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Bit 0 must always be clear; bit 1 only matters without compressed instructions.
    function automatic logic target_misaligned(input logic [1:0] low, input int ialign);
        return low[0] | ((ialign == 32) & low[1]);
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: base+imm with modular wrap, mode masking
// and alignment check.
module pc_target_calc #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic [1:0]      mode,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);
    import pc_pkg::*;

    logic [XLEN-1:0] sum;

    assign sum = base + imm;

    always_comb begin
        target = base;
        case (mode)
            PC_REL:  target = sum;
            REG_REL: target = {sum[XLEN-1:1], 1'b0};
            default: target = base;
        endcase
    end

    assign misaligned = target_misaligned(target[1:0], IALIGN);

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: valid/ready request port, trap/redirect priority,
// one-entry pending redirect, epoch tagging, misalignment report and WFI halt.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FETCH_BYTES  = 4,
    parameter int              IALIGN       = 32,
    parameter int              EPOCH_W      = 2
) (
    input  logic               clk,
    input  logic               areset,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [XLEN-1:0]    if_pc,
    output logic [EPOCH_W-1:0] if_epoch,
    output logic [EPOCH_W-1:0] cur_epoch,
    input  logic               redirect_valid,
    input  logic [1:0]         redirect_mode,
    input  logic [XLEN-1:0]    redirect_base,
    input  logic [XLEN-1:0]    redirect_imm,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_vector,
    input  logic               halt_req,
    output logic               halted,
    output logic               misalign_valid,
    output logic [XLEN-1:0]    misalign_addr,
    output logic [1:0]         fsm_state
);
    import pc_pkg::*;

    // Handshake: a request is offered while if_valid=1 and is consumed on
    // fire = if_valid & if_ready; until then if_pc/if_epoch stay frozen and
    // if_valid does not drop.

    pc_state_e        state_q;
    logic [XLEN-1:0]  redir_target;
    logic             redir_misaligned;
    logic [XLEN-1:0]  trap_target;
    logic [XLEN-1:0]  new_target;
    logic [XLEN-1:0]  win_target;
    logic             redir_ok;
    logic             misalign_evt;
    logic             new_win;
    logic             have_win;
    logic             fire;
    logic             stalled;
    logic             drop_redir;
    logic             accept_new;
    logic [EPOCH_W-1:0] epoch_next;

    logic             pend_valid;
    logic             pend_is_trap;
    logic [XLEN-1:0]  pend_target;

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_calc (
        .mode       (redirect_mode),
        .base       (redirect_base),
        .imm        (redirect_imm),
        .target     (redir_target),
        .misaligned (redir_misaligned)
    );

    assign trap_target  = {trap_vector[XLEN-1:2], 2'b00};
    assign redir_ok     = redirect_valid & ~trap_valid & ~redir_misaligned;
    assign misalign_evt = redirect_valid & ~trap_valid & redir_misaligned;
    assign new_win      = trap_valid | redir_ok;
    assign have_win     = new_win | pend_valid;
    assign new_target   = trap_valid ? trap_target : redir_target;
    assign win_target   = new_win ? new_target : pend_target;

    assign fire    = if_valid & if_ready;
    assign stalled = if_valid & ~if_ready;

    // A pending trap must survive a later redirect arriving during the same stall.
    assign drop_redir = stalled & redir_ok & pend_valid & pend_is_trap;
    assign accept_new = new_win & ~drop_redir;
    assign epoch_next = cur_epoch + EPOCH_W'(accept_new);

    assign if_valid  = (state_q == RUN);
    assign halted    = (state_q == HALT);
    assign fsm_state = state_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q        <= BOOT;
            if_pc          <= RESET_VECTOR;
            if_epoch       <= '0;
            cur_epoch      <= '0;
            pend_valid     <= 1'b0;
            pend_is_trap   <= 1'b0;
            pend_target    <= '0;
            misalign_valid <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            misalign_valid <= misalign_evt;
            if (misalign_evt) begin
                misalign_addr <= redir_target;
            end
            cur_epoch <= epoch_next;

            case (state_q)
                BOOT: begin
                    state_q  <= RUN;
                    if_epoch <= epoch_next;
                    if (have_win) begin
                        if_pc      <= win_target;
                        pend_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (fire) begin
                        if_epoch   <= epoch_next;
                        pend_valid <= 1'b0;
                        if (have_win) begin
                            if_pc <= win_target;
                        end else begin
                            if_pc <= if_pc + XLEN'(FETCH_BYTES);
                            if (halt_req) begin
                                state_q <= HALT;
                            end
                        end
                    end else if (accept_new) begin
                        pend_valid   <= 1'b1;
                        pend_is_trap <= trap_valid;
                        pend_target  <= new_target;
                    end
                end
                HALT: begin
                    if (have_win) begin
                        state_q    <= RUN;
                        if_pc      <= win_target;
                        if_epoch   <= epoch_next;
                        pend_valid <= 1'b0;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed scenarios followed by random
// traffic, checked against a transaction-level model of the fetch stream.
module tb_pc_gen_unit;
    import pc_pkg::*;

    localparam logic [31:0] RV = 32'h100;
    localparam int SW = 71;

    logic        clk = 1'b0;
    logic        areset;
    logic        if_valid, if_ready;
    logic [31:0] if_pc;
    logic [1:0]  if_epoch, cur_epoch;
    logic        redirect_valid;
    logic [1:0]  redirect_mode;
    logic [31:0] redirect_base, redirect_imm;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        halt_req, halted, misalign_valid;
    logic [31:0] misalign_addr;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    pc_gen_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .FETCH_BYTES(4), .IALIGN(32), .EPOCH_W(2)
    ) dut (
        .clk(clk), .areset(areset), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_epoch(if_epoch), .cur_epoch(cur_epoch),
        .redirect_valid(redirect_valid), .redirect_mode(redirect_mode),
        .redirect_base(redirect_base), .redirect_imm(redirect_imm),
        .trap_valid(trap_valid), .trap_vector(trap_vector), .halt_req(halt_req),
        .halted(halted), .misalign_valid(misalign_valid), .misalign_addr(misalign_addr),
        .fsm_state(fsm_state)
    );

    logic [SW-1:0] exp_q[$];
    logic [33:0]   fire_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = waiting after reset, 1 = issuing, 2 = asleep.
    int          m_mode;
    logic [31:0] m_pc;
    logic [1:0]  m_ep, m_cur;
    bit          m_pend, m_pend_trap;
    logic [31:0] m_pend_tgt;
    bit          m_mis_v;
    logic [31:0] m_mis_a;

    function automatic logic [31:0] calc_target(input logic [1:0] rm, input logic [31:0] b,
                                                input logic [31:0] i);
        if (rm == PC_REL)  return b + i;
        if (rm == REG_REL) return (b + i) & 32'hFFFF_FFFE;
        return b;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = RV; m_ep = 2'd0; m_cur = 2'd0;
        m_pend = 0; m_pend_trap = 0; m_pend_tgt = '0;
        m_mis_v = 0; m_mis_a = '0;
    endtask

    task automatic model_step(input bit rdy, input bit tv, input logic [31:0] tvec, input bit rv,
                              input logic [1:0] rm, input logic [31:0] rb, input logic [31:0] ri,
                              input bit hr);
        logic [31:0] rt, nt;
        bit bad, red, have_new, valid;
        valid    = (m_mode == 1);
        rt       = calc_target(rm, rb, ri);
        bad      = rv && !tv && (rt[1:0] != 2'b00);
        red      = rv && !tv && !bad;
        have_new = tv || red;
        nt       = tv ? (tvec & 32'hFFFF_FFFC) : rt;
        m_mis_v  = bad;
        if (bad) m_mis_a = rt;
        if (!valid || rdy) begin
            if (have_new || m_pend) begin
                if (have_new) m_cur = m_cur + 2'd1;
                m_pc   = have_new ? nt : m_pend_tgt;
                m_ep   = m_cur;
                m_pend = 0;
                m_mode = 1;
            end else if (m_mode == 0) begin
                m_mode = 1;
                m_ep   = m_cur;
            end else if (m_mode == 1) begin
                m_pc = m_pc + 32'd4;
                m_ep = m_cur;
                if (hr) m_mode = 2;
            end
        end else if (tv || (red && !(m_pend && m_pend_trap))) begin
            m_pend      = 1;
            m_pend_trap = tv;
            m_pend_tgt  = nt;
            m_cur       = m_cur + 2'd1;
        end
    endtask

    task automatic drive(input bit rst, input bit rdy, input bit tv, input logic [31:0] tvec,
                         input bit rv, input logic [1:0] rm, input logic [31:0] rb,
                         input logic [31:0] ri, input bit hr);
        @(posedge clk);
        #1;
        areset = rst; if_ready = rdy; trap_valid = tv; trap_vector = tvec;
        redirect_valid = rv; redirect_mode = rm; redirect_base = rb; redirect_imm = ri;
        halt_req = hr;
        if (rst) model_reset();
        exp_q.push_back({m_mode == 1, m_mode == 2, m_ep, m_cur, m_mis_v, m_mis_a, m_pc});
        if (m_mode == 1 && rdy) fire_q.push_back({m_ep, m_pc});
        if (!rst) model_step(rdy, tv, tvec, rv, rm, rb, ri, hr);
    endtask

    task automatic idle(input bit rdy);
        drive(0, rdy, 0, '0, 0, PC_REL, '0, '0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compares every cycle's visible state and each consumed request.
    logic [SW-1:0] got_s, exp_s;
    logic [33:0]   exp_f;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                got_s = {if_valid, halted, if_epoch, cur_epoch, misalign_valid, misalign_addr, if_pc};
                exp_s = exp_q.pop_front();
                n_vec++;
                if (got_s !== exp_s) begin
                    n_err++;
                    $display("FAIL status: got v=%b h=%b ep=%0d cur=%0d mv=%b ma=%h pc=%h, expected v=%b h=%b ep=%0d cur=%0d mv=%b ma=%h pc=%h",
                             got_s[70], got_s[69], got_s[68:67], got_s[66:65], got_s[64], got_s[63:32], got_s[31:0],
                             exp_s[70], exp_s[69], exp_s[68:67], exp_s[66:65], exp_s[64], exp_s[63:32], exp_s[31:0]);
                end
                if (if_valid && if_ready) begin
                    n_vec++;
                    if (fire_q.size() == 0) begin
                        n_err++;
                        $display("FAIL fire: got request pc=%h ep=%0d, expected no request", if_pc, if_epoch);
                    end else begin
                        exp_f = fire_q.pop_front();
                        if ({if_epoch, if_pc} !== exp_f) begin
                            n_err++;
                            $display("FAIL fire: got pc=%h ep=%0d, expected pc=%h ep=%0d",
                                     if_pc, if_epoch, exp_f[31:0], exp_f[33:32]);
                        end
                    end
                end
            end
        end
    end

    logic [31:0] r, rb, ri;
    logic [1:0]  rm;
    bit          rst_r, tv_r, rv_r, hr_r, rdy_r;

    initial begin
        areset = 1'b1; if_ready = 1'b0; trap_valid = 1'b0; trap_vector = '0;
        redirect_valid = 1'b0; redirect_mode = PC_REL; redirect_base = '0; redirect_imm = '0;
        halt_req = 1'b0;
        model_reset();

        // Reset and sequential stream from the reset vector.
        drive(1, 1, 0, '0, 0, PC_REL, '0, '0, 0);
        drive(1, 1, 0, '0, 0, PC_REL, '0, '0, 0);
        repeat (5) idle(1);

        // Redirect captured while stalled, applied after the stall.
        drive(0, 1, 1, 32'h10, 0, PC_REL, '0, '0, 0);
        drive(0, 0, 0, '0, 1, PC_REL, 32'h10, 32'h40, 0);
        idle(0);
        idle(1);
        idle(1);

        // Trap beats a simultaneous redirect; vector low bits cleared.
        drive(0, 1, 1, 32'h203, 1, PC_REL, 32'h50, 32'h8, 0);
        idle(1);

        // Misaligned REG_REL target is reported and discarded.
        drive(0, 1, 0, '0, 1, REG_REL, 32'h1001, 32'h2, 0);
        idle(1);
        idle(1);

        // Wrap-around at the top of the address space.
        drive(0, 1, 1, 32'hFFFF_FFFC, 0, PC_REL, '0, '0, 0);
        repeat (3) idle(1);

        // Pending trap survives a later redirect in the same stall.
        drive(0, 0, 1, 32'h400, 0, PC_REL, '0, '0, 0);
        drive(0, 0, 0, '0, 1, ABS, 32'h500, '0, 0);
        idle(1);
        idle(1);

        // Halt at 0x20, wake on trap, then async reset during a stall.
        drive(0, 1, 1, 32'h1C, 0, PC_REL, '0, '0, 0);
        idle(1);
        drive(0, 1, 0, '0, 0, PC_REL, '0, '0, 1);
        idle(0);
        idle(1);
        drive(0, 0, 1, 32'h300, 0, PC_REL, '0, '0, 0);
        idle(0);
        idle(0);
        drive(1, 0, 0, '0, 0, PC_REL, '0, '0, 0);
        #1;
        chk("reset_if_valid", {31'd0, if_valid}, 32'd0);
        chk("reset_if_pc", if_pc, RV);
        chk("reset_if_epoch", {30'd0, if_epoch}, 32'd0);
        chk("reset_cur_epoch", {30'd0, cur_epoch}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_misalign", {31'd0, misalign_valid}, 32'd0);
        drive(1, 0, 0, '0, 0, PC_REL, '0, '0, 0);
        repeat (3) idle(1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 499) == 0);
            rdy_r = ($urandom_range(0, 9) < 7);
            tv_r  = ($urandom_range(0, 19) == 0);
            rv_r  = ($urandom_range(0, 6) == 0);
            hr_r  = ($urandom_range(0, 14) == 0);
            rm    = 2'($urandom_range(0, 3));
            r     = $urandom;
            rb    = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
            if ($urandom_range(0, 15) == 0) rb = 32'hFFFF_FFF0;
            r     = $urandom_range(0, 255);
            ri    = ($urandom_range(0, 1) == 0) ? r : -r;
            if ($urandom_range(0, 3) != 0) ri = ri & 32'hFFFF_FFFC;
            r     = $urandom;
            if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF8;
            drive(rst_r, rdy_r, tv_r, r, rv_r, rm, rb, ri, hr_r);
        end
        idle(1);
        @(negedge clk);
        #1;

        n_vec++;
        if (exp_q.size() != 0 || fire_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d status and %0d requests left, expected 0 and 0",
                     exp_q.size(), fire_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
